// File: rtl/store_drain_ctrl_if.sv
// Commit-side, D-cache-side and load-check signals of the store drain controller.
// The DUT attaches through the slave modport; the commit/cache/load side uses master.
interface store_drain_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              st_commit;
   logic [ADDR_W-1:0] st_addr;
   logic [DATA_W-1:0] st_data;
   logic              buf_full;
   logic              buf_empty;
   logic              dc_req;
   logic [ADDR_W-1:0] dc_addr;
   logic [DATA_W-1:0] dc_data;
   logic              dc_ack;
   logic              ld_chk;
   logic [ADDR_W-1:0] ld_addr;
   logic              ld_hit;
   logic [DATA_W-1:0] ld_fwd_data;
   logic              drained;
   logic              overflow_err;

   modport slave (
      input  st_commit, st_addr, st_data, dc_ack, ld_chk, ld_addr,
      output buf_full, buf_empty, dc_req, dc_addr, dc_data,
             ld_hit, ld_fwd_data, drained, overflow_err
   );

   modport master (
      output st_commit, st_addr, st_data, dc_ack, ld_chk, ld_addr,
      input  buf_full, buf_empty, dc_req, dc_addr, dc_data,
             ld_hit, ld_fwd_data, drained, overflow_err
   );
endinterface

// File: rtl/store_drain_ctrl.sv
// Post-commit store FIFO: drains stores in order to the D-cache over req/ack
// and offers word-granular forwarding of the youngest pending store to loads.
module store_drain_ctrl #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   store_drain_ctrl_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic {S_IDLE, S_REQ} state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   head_q, head_d;
   logic [PTR_W-1:0]   tail_q, tail_d;
   logic [PTR_W:0]     count_q, count_d;
   logic               overflow_q, overflow_d;
   logic [ADDR_W-1:0]  addr_mem_q [DEPTH];
   logic [DATA_W-1:0]  data_mem_q [DEPTH];

   logic               full, empty, push, pop, req;
   logic [DEPTH-1:0]   match;
   logic               hit_any;
   logic [PTR_W-1:0]   fwd_idx;
   logic [DATA_W-1:0]  fwd_data;
   logic               unused_ld_lsb;

   assign full  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign req   = (state_q == S_REQ);
   assign push  = bus.st_commit && !full;
   assign pop   = req && bus.dc_ack;

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      overflow_d = overflow_q | (bus.st_commit & full);
      state_d    = state_q;
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
      // Looking at the post-update count lets a fresh store be requested the very next cycle.
      case (state_q)
         S_IDLE:  if (count_d != '0) state_d = S_REQ;
         S_REQ:   if (count_d == '0) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem_q[tail_q] <= bus.st_addr;
         data_mem_q[tail_q] <= bus.st_data;
      end
   end

   // An entry is live when its distance from head is below count.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PTR_W-1:0] age;
      assign age       = PTR_W'(gi) - head_q;
      assign match[gi] = ({1'b0, age} < count_q) &&
                         (addr_mem_q[gi][ADDR_W-1:2] == bus.ld_addr[ADDR_W-1:2]);
   end

   always_comb begin
      fwd_data = '0;
      fwd_idx  = '0;
      hit_any  = |match;
      for (int k = 0; k < DEPTH; k++) begin
         fwd_idx = head_q + PTR_W'(k);
         if (match[fwd_idx]) fwd_data = data_mem_q[fwd_idx];
      end
   end

   assign unused_ld_lsb = ^bus.ld_addr[1:0];

   assign bus.buf_full     = full;
   assign bus.buf_empty    = empty;
   assign bus.dc_req       = req;
   assign bus.dc_addr      = req ? addr_mem_q[head_q] : '0;
   assign bus.dc_data      = req ? data_mem_q[head_q] : '0;
   assign bus.ld_hit       = bus.ld_chk && hit_any;
   assign bus.ld_fwd_data  = (bus.ld_chk && hit_any) ? fwd_data : '0;
   assign bus.drained      = empty && (state_q == S_IDLE);
   assign bus.overflow_err = overflow_q;
endmodule
